gcd_unit: RTL and testbench
===========================

Name: gcd_unit

Overview:
- Parametrised successor to the team's 8-bit subtractive GCD circuit.
- Computes gcd(ina, inb) for WIDTH-bit unsigned operands under a start/ready handshake.
- Runtime-selectable algorithm: subtractive Euclid or binary (Stein).
- Adds a done pulse, a zero-operand error flag and a saturating per-run cycle counter. Sits as a slave arithmetic unit under a sequencer that polls ready.

Parameters:
WIDTH, 8, operand and result width in bits (>=2)
CNTW, 16, width of the cycle counter output

Ports:
clk  in  1  rising-edge clock
nrst  in  1  reset, asynchronous, active-low
start  in  1  request; accepted only when ready=1
mode  in  1  0 = subtractive Euclid, 1 = binary Stein; sampled with start
ina  in  WIDTH  operand A; sampled with start
inb  in  WIDTH  operand B; sampled with start
ready  out  1  1 = idle, start will be accepted
done  out  1  one-cycle pulse: out/err/cycles just updated
err  out  1  1 = last run had ina=inb=0; held until next completion
out  out  WIDTH  last GCD result; held until next completion
cycles  out  CNTW  CALC cycles used by the last run; saturates at all-ones

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, nrst).
- Reset (asynchronous, any state including mid-run):
  - state=IDLE, ready=1, done=0, err=0, out=0, cycles=0.
  - Internal a, b, k and counter cleared.
  - No partial result survives.
- States:
  - IDLE: ready=1. On an edge with start=1, latch a=ina, b=inb, mode, k=0, cnt=0. Next state CALC, ready=0.
  - CALC: ready=0. start is ignored. Exactly one step per edge; cnt increments by 1 per step, saturating at 2^CNTW-1.
  - A step either updates a/b/k or terminates.
- Step priority, identical in both modes:
  1. a==b: terminate with result a<<k; err=(a==0).
  2. a==0: terminate with result b<<k.
  3. b==0: terminate with result a<<k.
  4. Mode-specific step.
- Subtractive step (mode 0):
  - a<b: swap a and b.
  - Otherwise: a <= a-b.
- Stein step (mode 1):
  - Both even: a>>=1, b>>=1, k+=1.
  - Only a even: a>>=1.
  - Only b even: b>>=1.
  - Both odd: if a>b then a<=a-b, else b<=b-a.
- Terminating edge:
  - out<=result, err updated, cycles<=cnt+1 (saturating).
  - done<=1, ready<=1, state<=IDLE.
  - done drops on the following edge.
- Latency: start edge, then N CALC edges; done/ready high after the Nth. Minimum N=1 (equal or zero operand).
- Width rules:
  - k is clog2(WIDTH+1) bits.
  - a<<k never exceeds the original operand, so out fits WIDTH with no truncation.
  - Subtraction never underflows, given the guards above.
- Simultaneous events:
  - start in the same cycle as done/ready rising is accepted; the new run begins immediately.
  - out, err and cycles keep their values until the new run completes.
- start held high in IDLE re-triggers each time ready returns.

Decomposition:
- gcd_pkg:
  - state enum {IDLE, CALC}.
  - mode enum {MODE_SUB=0, MODE_STEIN=1}.
  - Helper function for the saturating increment.
- One sub-module, gcd_datapath:
  - Registers a, b, k and cnt.
  - Step logic and the term/result/err signals.
- Top gcd_unit holds the state register, handshake and output registers.

Test Plan:
- Reset mid-run: start mode0 a=255 b=1; assert nrst=0 after 10 cycles -> immediately ready=1, done=0, out=0, cycles=0, err=0 with no clock edge. After release, start a=8 b=8 -> out=8, cycles=1.
- Mode0 a=12 b=18 -> steps swap, sub, swap, sub, equal. done high exactly 5 edges after the start edge; out=6, cycles=5, err=0.
- Mode1 a=12 b=18 -> (6,9,k1), (3,9), (3,6), (3,3). out=3<<1=6, cycles=5.
- Zero cases:
  - a=0 b=7 (either mode) -> out=7, cycles=1, err=0.
  - a=0 b=0 -> out=0, err=1, cycles=1.
  - Then a=4 b=6 -> err returns to 0, out=2.
- Handshake: pulse start during CALC with a=9 b=3 -> ignored, first result unchanged. Start held high across a done -> a second run starts on the done cycle, and out/cycles hold until it ends.
- WIDTH=16, CNTW=4, mode0 a=65535 b=1 -> out=1, cycles=15 (saturated). A scoreboard sweep over random pairs checks both modes against a reference gcd.

Source files
------------

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared types and helpers for the gcd_unit slice.
//   gcd_state_e : control FSM states (IDLE, CALC)
//   gcd_mode_e  : algorithm select sampled with start (MODE_SUB, MODE_STEIN)
//   sat_inc     : saturating increment; operands up to SAT_W bits wide
package gcd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } gcd_state_e;

  typedef enum logic {
    MODE_SUB   = 1'b0,
    MODE_STEIN = 1'b1
  } gcd_mode_e;

  // Callers zero-extend their counter into this width and cast back.
  localparam int unsigned SAT_W = 32;

  // Increment val, sticking at lim once it is reached.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                               input logic [SAT_W-1:0] lim);
    logic [SAT_W-1:0] res;
    if (val >= lim) begin
      res = val;
    end else begin
      res = val + 32'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/gcd_datapath.sv
// gcd_datapath: operand registers and one-step-per-edge GCD iteration.
//   clk, nrst  : clock, async active-low reset
//   load       : latch ina/inb/mode, clear k and the step counter
//   step       : unit is in CALC; apply one step unless term is high
//   mode, ina, inb : run parameters, sampled on load
//   term       : current operands end the run this edge
//   result     : GCD to publish when term is high
//   err_zero   : both operands are zero (valid with term)
//   cnt_next   : step count including the current edge, saturating
module gcd_datapath #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             load,
  input  logic             step,
  input  logic             mode,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  output logic             term,
  output logic [WIDTH-1:0] result,
  output logic             err_zero,
  output logic [CNTW-1:0]  cnt_next
);
  import gcd_pkg::*;

  // k counts shared factors of two removed by Stein; at most WIDTH of them.
  localparam int KW = $clog2(WIDTH + 1);
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  logic [WIDTH-1:0] a_r, b_r;
  logic [KW-1:0]    k_r;
  logic [CNTW-1:0]  cnt_r;
  gcd_mode_e        mode_r;

  logic [WIDTH-1:0] a_nxt_s, b_nxt_s;
  logic [KW-1:0]    k_nxt_s;
  logic             term_s, err_s;
  logic [WIDTH-1:0] result_s;

  assign cnt_next = CNTW'(sat_inc(32'(cnt_r), 32'(CNT_MAX)));
  assign term     = term_s;
  assign result   = result_s;
  assign err_zero = err_s;

  // Step logic: termination checks first, then the mode-specific reduction.
  always_comb begin
    a_nxt_s  = a_r;
    b_nxt_s  = b_r;
    k_nxt_s  = k_r;
    term_s   = 1'b0;
    err_s    = 1'b0;
    result_s = a_r << k_r;
    if (a_r == b_r) begin
      term_s   = 1'b1;
      result_s = a_r << k_r;
      err_s    = (a_r == {WIDTH{1'b0}});
    end else if (a_r == {WIDTH{1'b0}}) begin
      term_s   = 1'b1;
      result_s = b_r << k_r;
    end else if (b_r == {WIDTH{1'b0}}) begin
      term_s   = 1'b1;
      result_s = a_r << k_r;
    end else begin
      case (mode_r)
        MODE_SUB: begin
          if (a_r < b_r) begin
            a_nxt_s = b_r;
            b_nxt_s = a_r;
          end else begin
            a_nxt_s = a_r - b_r;
          end
        end
        MODE_STEIN: begin
          if (!a_r[0] && !b_r[0]) begin
            a_nxt_s = a_r >> 1;
            b_nxt_s = b_r >> 1;
            k_nxt_s = k_r + {{(KW-1){1'b0}}, 1'b1};
          end else if (!a_r[0]) begin
            a_nxt_s = a_r >> 1;
          end else if (!b_r[0]) begin
            b_nxt_s = b_r >> 1;
          end else if (a_r > b_r) begin
            a_nxt_s = a_r - b_r;
          end else begin
            b_nxt_s = b_r - a_r;
          end
        end
        default: begin
          a_nxt_s = a_r;
        end
      endcase
    end
  end

  // Operand/counter registers: load on accept, advance on non-terminal steps.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      a_r    <= {WIDTH{1'b0}};
      b_r    <= {WIDTH{1'b0}};
      k_r    <= {KW{1'b0}};
      cnt_r  <= {CNTW{1'b0}};
      mode_r <= MODE_SUB;
    end else if (load) begin
      a_r    <= ina;
      b_r    <= inb;
      k_r    <= {KW{1'b0}};
      cnt_r  <= {CNTW{1'b0}};
      mode_r <= gcd_mode_e'(mode);
    end else if (step && !term_s) begin
      a_r   <= a_nxt_s;
      b_r   <= b_nxt_s;
      k_r   <= k_nxt_s;
      cnt_r <= cnt_next;
    end
  end

endmodule

// File: rtl/gcd_unit.sv
// gcd_unit: start/ready GCD slave with selectable subtractive or Stein algorithm.
//   clk, nrst      : clock, async active-low reset
//   start          : run request, accepted only while ready=1
//   mode           : 0 subtractive Euclid, 1 binary Stein (sampled with start)
//   ina, inb       : WIDTH-bit operands (sampled with start)
//   ready          : idle, next start will be accepted
//   done           : one-cycle pulse when out/err/cycles update
//   err            : last run had both operands zero
//   out            : last GCD result
//   cycles         : CALC cycles used by the last run, saturating
module gcd_unit #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  output logic             ready,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] out,
  output logic [CNTW-1:0]  cycles
);
  import gcd_pkg::*;

  gcd_state_e       state_r;
  logic             ready_r, done_r, err_r;
  logic [WIDTH-1:0] out_r;
  logic [CNTW-1:0]  cycles_r;

  logic             load_s, step_s, term_s, err_s;
  logic [WIDTH-1:0] result_s;
  logic [CNTW-1:0]  cnt_next_s;

  // start is only honoured in IDLE; during CALC it is ignored entirely.
  assign load_s = (state_r == IDLE) && start;
  assign step_s = (state_r == CALC);

  gcd_datapath #(
    .WIDTH (WIDTH),
    .CNTW  (CNTW)
  ) u_datapath (
    .clk      (clk),
    .nrst     (nrst),
    .load     (load_s),
    .step     (step_s),
    .mode     (mode),
    .ina      (ina),
    .inb      (inb),
    .term     (term_s),
    .result   (result_s),
    .err_zero (err_s),
    .cnt_next (cnt_next_s)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r  <= IDLE;
      ready_r  <= 1'b1;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      out_r    <= {WIDTH{1'b0}};
      cycles_r <= {CNTW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r <= CALC;
            ready_r <= 1'b0;
          end
        end
        CALC: begin
          if (term_s) begin
            state_r  <= IDLE;
            ready_r  <= 1'b1;
            done_r   <= 1'b1;
            out_r    <= result_s;
            err_r    <= err_s;
            cycles_r <= cnt_next_s;
          end else begin
            done_r <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign ready  = ready_r;
  assign done   = done_r;
  assign err    = err_r;
  assign out    = out_r;
  assign cycles = cycles_r;

endmodule

// File: tb/tb_gcd_unit.sv
module tb_gcd_unit;

  localparam int LAT_LIMIT = 2000;

  logic       clk;
  logic       nrst;
  logic       start, mode;
  logic [7:0] ina, inb;
  logic       ready, done, err;
  logic [7:0] out;
  logic [15:0] cycles;

  logic        start16, mode16;
  logic [15:0] ina16, inb16;
  logic        ready16, done16, err16;
  logic [15:0] out16;
  logic [3:0]  cycles16;

  int n_checks;
  int n_fail;

  gcd_unit #(.WIDTH(8), .CNTW(16)) u_dut (
    .clk(clk), .nrst(nrst), .start(start), .mode(mode), .ina(ina), .inb(inb),
    .ready(ready), .done(done), .err(err), .out(out), .cycles(cycles)
  );

  gcd_unit #(.WIDTH(16), .CNTW(4)) u_dut16 (
    .clk(clk), .nrst(nrst), .start(start16), .mode(mode16), .ina(ina16), .inb(inb16),
    .ready(ready16), .done(done16), .err(err16), .out(out16), .cycles(cycles16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       m;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_out;
    logic       exp_err;
    int         exp_cyc;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_gcd(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, q, t;
    p = x;
    q = y;
    while (q != 8'd0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // Launch one run on the 8-bit DUT from idle; lat = edges after the start edge.
  task automatic run8(input logic m, input logic [7:0] a, input logic [7:0] b, output int lat);
    mode  = m;
    ina   = a;
    inb   = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < LAT_LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    int lat;
    logic [7:0] ra, rb;
    n_checks = 0;
    n_fail   = 0;
    nrst = 1'b0;
    start = 1'b0; mode = 1'b0; ina = 8'd0; inb = 8'd0;
    start16 = 1'b0; mode16 = 1'b0; ina16 = 16'd0; inb16 = 16'd0;

    vecs[0]  = '{1'b0, 8'd12, 8'd18, 8'd6, 1'b0, 5};
    vecs[1]  = '{1'b1, 8'd12, 8'd18, 8'd6, 1'b0, 5};
    vecs[2]  = '{1'b0, 8'd0,  8'd7,  8'd7, 1'b0, 1};
    vecs[3]  = '{1'b1, 8'd0,  8'd7,  8'd7, 1'b0, 1};
    vecs[4]  = '{1'b0, 8'd0,  8'd0,  8'd0, 1'b1, 1};
    vecs[5]  = '{1'b0, 8'd4,  8'd6,  8'd2, 1'b0, 5};
    vecs[6]  = '{1'b1, 8'd0,  8'd0,  8'd0, 1'b1, 1};
    vecs[7]  = '{1'b1, 8'd4,  8'd6,  8'd2, 1'b0, 5};
    vecs[8]  = '{1'b0, 8'd7,  8'd0,  8'd7, 1'b0, 1};
    vecs[9]  = '{1'b1, 8'd16, 8'd24, 8'd8, 1'b0, 7};
    vecs[10] = '{1'b0, 8'd9,  8'd3,  8'd3, 1'b0, 3};
    vecs[11] = '{1'b1, 8'd5,  8'd3,  8'd1, 1'b0, 5};
    vecs[12] = '{1'b0, 8'd5,  8'd3,  8'd1, 1'b0, 6};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_cycles", 32'(cycles), 32'd0);
    nrst = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 13; i++) begin
      run8(vecs[i].m, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_out", i), 32'(out), 32'(vecs[i].exp_out));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_cycles", i), 32'(cycles), 32'(vecs[i].exp_cyc));
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_cyc));
      chk($sformatf("v%0d_ready", i), 32'(ready), 32'd1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_drop", i), 32'(done), 32'd0);
    end

    // start pulsed during CALC is ignored
    mode = 1'b0; ina = 8'd12; inb = 8'd18; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    ina = 8'd9; inb = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 2;
    while (done !== 1'b1 && lat < LAT_LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ign_lat", 32'(lat), 32'd5);
    chk("ign_out", 32'(out), 32'd6);
    chk("ign_cycles", 32'(cycles), 32'd5);
    @(posedge clk); #1;
    chk("ign_no_rerun", 32'(ready), 32'd1);

    // start held high across done: second run starts on the done cycle
    mode = 1'b0; ina = 8'd12; inb = 8'd18; start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (done !== 1'b1 && lat < LAT_LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("held_lat1", 32'(lat), 32'd5);
    chk("held_out1", 32'(out), 32'd6);
    ina = 8'd9; inb = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    chk("held_busy", 32'(ready), 32'd0);
    chk("held_out_hold", 32'(out), 32'd6);
    chk("held_cyc_hold", 32'(cycles), 32'd5);
    lat = 0;
    while (done !== 1'b1 && lat < LAT_LIMIT) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("held_lat2", 32'(lat), 32'd3);
    chk("held_out2", 32'(out), 32'd3);
    chk("held_cyc2", 32'(cycles), 32'd3);

    // Asynchronous reset mid-run
    @(posedge clk); #1;
    mode = 1'b0; ina = 8'd255; inb = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_ready", 32'(ready), 32'd1);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_out", 32'(out), 32'd0);
    chk("arst_cycles", 32'(cycles), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;
    run8(1'b0, 8'd8, 8'd8, lat);
    chk("post_rst_out", 32'(out), 32'd8);
    chk("post_rst_cycles", 32'(cycles), 32'd1);
    @(posedge clk); #1;

    // Scoreboard sweep against a modulo-based reference
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 16; i++) begin
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        run8(m[0], ra, rb, lat);
        chk($sformatf("rnd_m%0d_%0d_%0d_out", m, ra, rb), 32'(out), 32'(ref_gcd(ra, rb)));
        chk($sformatf("rnd_m%0d_%0d_%0d_err", m, ra, rb), 32'(err),
            32'((ra == 8'd0) && (rb == 8'd0)));
        chk($sformatf("rnd_m%0d_cyc", m), 32'(cycles), 32'(lat));
        @(posedge clk); #1;
      end
    end

    // Saturating counter on the 16-bit / 4-bit-counter instance
    mode16 = 1'b0; ina16 = 16'd65535; inb16 = 16'd1; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = 0;
    while (done16 !== 1'b1 && lat < 70000) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("sat_done", 32'(done16), 32'd1);
    chk("sat_lat", 32'(lat), 32'd65535);
    chk("sat_out", 32'(out16), 32'd1);
    chk("sat_cycles", 32'(cycles16), 32'd15);
    chk("sat_err", 32'(err16), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
